// File: rtl/instruction_fetch.sv
// Instruction fetch: issues program-memory reads from the external PC and queues {word, address}
// pairs for decode. Defining IFETCH_STALL_COUNT_EN adds the StallCount output.
module instruction_fetch (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [15:0] CounterValue,
   output logic [15:0] PcLoadValue,
   output logic        PcLoadEnable,
   output logic [15:0] MemAddress,
   output logic        MemReadEnable,
   input  logic [15:0] MemData,
   input  logic        Flush,
   input  logic [15:0] FlushAddress,
   output logic [15:0] Instruction,
   output logic [15:0] InstrAddress,
   output logic        InstrValid,
   input  logic        InstrReady
`ifdef IFETCH_STALL_COUNT_EN
   ,
   output logic [15:0] StallCount
`endif
);

   localparam int DEPTH = 4;

   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } fetch_state_t;

   fetch_state_t state_reg;
   fetch_state_t state_next;

   logic [15:0] fifo_data_reg [DEPTH];
   logic [15:0] fifo_addr_reg [DEPTH];
   logic [1:0]  wr_ptr_reg;
   logic [1:0]  rd_ptr_reg;
   logic [2:0]  count_reg;
   logic        inflight_reg;
   logic [15:0] inflight_addr_reg;

   logic        fifo_empty;
   logic        pop;
   logic        push;
   logic        credit;
   logic        issue;
   logic [3:0]  occupancy_eff;

   assign fifo_empty = (count_reg == 3'd0);

   // Flush outranks both FIFO operations; reset silences everything.
   assign pop  = Reset & ~Flush & ~fifo_empty & InstrReady;
   assign push = Reset & ~Flush & inflight_reg;

   // A slot must exist for every word already buffered or still returning from memory.
   assign occupancy_eff = {1'b0, count_reg} + {3'b000, inflight_reg} - {3'b000, pop};
   assign credit        = (occupancy_eff < 4'd4);

   always_comb begin
      state_next    = state_reg;
      issue         = 1'b0;
      MemReadEnable = 1'b0;
      MemAddress    = 16'h0000;
      PcLoadEnable  = 1'b0;
      PcLoadValue   = 16'h0000;
      if (!Reset) begin
         state_next = RUN;
      end else if (Flush) begin
         state_next   = RUN;
         PcLoadEnable = 1'b1;
         PcLoadValue  = FlushAddress;
      end else begin
         case (state_reg)
            RUN:   if (!credit) state_next = STALL;
            STALL: if (credit)  state_next = RUN;
         endcase
         if (state_next == RUN) begin
            issue         = 1'b1;
            MemReadEnable = 1'b1;
            MemAddress    = CounterValue;
         end else begin
            // Reload the PC with its own value so it does not advance past the unfetched word.
            PcLoadEnable = 1'b1;
            PcLoadValue  = CounterValue;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_reg         <= RUN;
         inflight_reg      <= 1'b0;
         inflight_addr_reg <= 16'h0000;
         wr_ptr_reg        <= 2'd0;
         rd_ptr_reg        <= 2'd0;
         count_reg         <= 3'd0;
      end else begin
         state_reg    <= state_next;
         inflight_reg <= issue;
         if (issue) begin
            inflight_addr_reg <= CounterValue;
         end
         if (Flush) begin
            wr_ptr_reg <= 2'd0;
            rd_ptr_reg <= 2'd0;
            count_reg  <= 3'd0;
         end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 2'd1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 2'd1;
            case ({push, pop})
               2'b10:   count_reg <= count_reg + 3'd1;
               2'b01:   count_reg <= count_reg - 3'd1;
               default: count_reg <= count_reg;
            endcase
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (push) begin
         fifo_data_reg[wr_ptr_reg] <= MemData;
         fifo_addr_reg[wr_ptr_reg] <= inflight_addr_reg;
      end
   end

   // Outputs read as zero when nothing is valid, so stale or uninitialised entries never leak.
   assign InstrValid   = Reset & ~fifo_empty;
   assign Instruction  = InstrValid ? fifo_data_reg[rd_ptr_reg] : 16'h0000;
   assign InstrAddress = InstrValid ? fifo_addr_reg[rd_ptr_reg] : 16'h0000;

`ifdef IFETCH_STALL_COUNT_EN
   logic [15:0] stall_count_reg;

   always_ff @(posedge Clock) begin
      if (!Reset || Flush) begin
         stall_count_reg <= 16'h0000;
      end else if ((state_next == STALL) && (stall_count_reg != 16'hFFFF)) begin
         stall_count_reg <= stall_count_reg + 16'd1;
      end
   end

   assign StallCount = stall_count_reg;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: external PC and registered XOR-5A5A memory models,
// expected {address, word} pairs queued at stimulus time and popped on each decode handshake.
`timescale 1ns/1ps
module tb_instruction_fetch;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [15:0] CounterValue;
   logic [15:0] PcLoadValue;
   logic        PcLoadEnable;
   logic [15:0] MemAddress;
   logic        MemReadEnable;
   logic [15:0] MemData;
   logic        Flush;
   logic [15:0] FlushAddress;
   logic [15:0] Instruction;
   logic [15:0] InstrAddress;
   logic        InstrValid;
   logic        InstrReady;
`ifdef IFETCH_STALL_COUNT_EN
   logic [15:0] StallCount;
`endif

   typedef struct {
      logic [15:0] addr;
      logic [15:0] data;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [15:0] pc_reg   = 16'h0000;
   logic [15:0] mem_data = 16'h0000;

   always #5 Clock = ~Clock;

   // Program counter: cleared in reset, loaded on request, otherwise advances by one.
   always @(posedge Clock) begin
      if (!Reset)            pc_reg <= 16'h0000;
      else if (PcLoadEnable) pc_reg <= PcLoadValue;
      else                   pc_reg <= pc_reg + 16'd1;
   end

   always @(posedge Clock) begin
      if (MemReadEnable) mem_data <= MemAddress ^ 16'h5A5A;
   end

   assign CounterValue = pc_reg;
   assign MemData      = mem_data;

   instruction_fetch dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .CounterValue (CounterValue),
      .PcLoadValue  (PcLoadValue),
      .PcLoadEnable (PcLoadEnable),
      .MemAddress   (MemAddress),
      .MemReadEnable(MemReadEnable),
      .MemData      (MemData),
      .Flush        (Flush),
      .FlushAddress (FlushAddress),
      .Instruction  (Instruction),
      .InstrAddress (InstrAddress),
      .InstrValid   (InstrValid),
      .InstrReady   (InstrReady)
`ifdef IFETCH_STALL_COUNT_EN
      ,
      .StallCount   (StallCount)
`endif
   );

   task automatic push_expected(input logic [15:0] first, input int n);
      exp_t e;
      logic [15:0] a;
      a = first;
      for (int i = 0; i < n; i++) begin
         e.addr = a;
         e.data = a ^ 16'h5A5A;
         exp_q.push_back(e);
         a = a + 16'd1;
      end
   endtask

   // Holds reset for three edges; returns at the start of the first cycle with Reset high.
   task automatic do_reset(input logic ready);
      @(posedge Clock); #1;
      Reset = 1'b0; Flush = 1'b0; FlushAddress = 16'h0000; InstrReady = ready;
      exp_q.delete();
      repeat (3) @(posedge Clock);
      #1;
      Reset = 1'b1;
   endtask

   task automatic test_reset();
      @(posedge Clock); #1;
      Reset = 1'b0; Flush = 1'b1; FlushAddress = 16'h1234; InstrReady = 1'b1;
      repeat (3) @(posedge Clock);
      @(negedge Clock);
      n_checks++;
      if ({MemReadEnable, PcLoadEnable, InstrValid} !== 3'b000 || PcLoadValue !== 16'h0 ||
          MemAddress !== 16'h0 || Instruction !== 16'h0 || InstrAddress !== 16'h0) begin
         n_errors++;
         $display("FAIL reset_outputs: got mre=%b ple=%b iv=%b plv=%h ma=%h ins=%h ia=%h, required all 0",
                  MemReadEnable, PcLoadEnable, InstrValid, PcLoadValue, MemAddress, Instruction, InstrAddress);
      end
      $display("[reset] outputs sampled during reset with Flush high");
   endtask

   task automatic test_stream();
      exp_t e;
      int first_valid = -1;
      do_reset(1'b1);
      push_expected(16'h0000, 8);
      for (int c = 0; c < 40; c++) begin
         @(negedge Clock);
         if (c == 0) begin
            n_checks++;
            if (MemReadEnable !== 1'b1 || MemAddress !== 16'h0000 || PcLoadEnable !== 1'b0) begin
               n_errors++;
               $display("FAIL stream_first_read: got mre=%b ma=%h ple=%b, required 1/0000/0",
                        MemReadEnable, MemAddress, PcLoadEnable);
            end
         end
         if (first_valid < 0 && InstrValid === 1'b1) first_valid = c;
         if (first_valid >= 0 && exp_q.size() != 0 && InstrValid !== 1'b1) begin
            n_checks++; n_errors++;
            $display("FAIL stream_gap: InstrValid=%b in cycle %0d, required 1", InstrValid, c);
         end
         if (InstrValid && InstrReady) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL stream_word: unexpected addr=%h data=%h", InstrAddress, Instruction);
            end else begin
               e = exp_q.pop_front();
               if (InstrAddress !== e.addr || Instruction !== e.data) begin
                  n_errors++;
                  $display("FAIL stream_word: got addr=%h data=%h, required addr=%h data=%h",
                           InstrAddress, Instruction, e.addr, e.data);
               end else $display("[stream] addr=%h data=%h", InstrAddress, Instruction);
            end
         end
         if (exp_q.size() == 0) break;
         @(posedge Clock); #1;
      end
      n_checks++;
      if (first_valid != 2) begin
         n_errors++;
         $display("FAIL stream_latency: first InstrValid cycle %0d, required 2", first_valid);
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL stream_timeout: %0d words undelivered, required 0", exp_q.size());
      end
   endtask

   task automatic test_backpressure();
      exp_t e;
      do_reset(1'b0);
      for (int c = 0; c < 10; c++) begin
         @(negedge Clock);
         if (c == 9) begin
            n_checks++;
            if (MemReadEnable !== 1'b0 || PcLoadEnable !== 1'b1 || PcLoadValue !== 16'h0004 ||
                InstrValid !== 1'b1 || InstrAddress !== 16'h0000) begin
               n_errors++;
               $display("FAIL bp_stall: got mre=%b ple=%b plv=%h iv=%b ia=%h, required 0/1/0004/1/0000",
                        MemReadEnable, PcLoadEnable, PcLoadValue, InstrValid, InstrAddress);
            end
         end
         @(posedge Clock); #1;
      end
      InstrReady = 1'b1;
      push_expected(16'h0000, 8);
      for (int c = 0; c < 30 && exp_q.size() != 0; c++) begin
         if (c != 0) begin @(posedge Clock); #1; end
         @(negedge Clock);
         if (c == 0) begin
            n_checks++;
            if (MemReadEnable !== 1'b1 || MemAddress !== 16'h0004) begin
               n_errors++;
               $display("FAIL bp_resume_read: got mre=%b ma=%h, required 1/0004", MemReadEnable, MemAddress);
            end
         end
         n_checks++;
         if (InstrValid !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_gap: InstrValid=%b at drain cycle %0d, required 1", InstrValid, c);
         end else begin
            e = exp_q.pop_front();
            if (InstrAddress !== e.addr || Instruction !== e.data) begin
               n_errors++;
               $display("FAIL bp_word: got addr=%h data=%h, required addr=%h data=%h",
                        InstrAddress, Instruction, e.addr, e.data);
            end else $display("[backpressure] addr=%h data=%h", InstrAddress, Instruction);
         end
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL bp_timeout: %0d words undelivered, required 0", exp_q.size());
      end
   endtask

   task automatic test_flush();
      exp_t e;
      do_reset(1'b0);
      repeat (4) @(posedge Clock);
      #1;
      Flush = 1'b1; FlushAddress = 16'h0100;
      @(negedge Clock);
      n_checks++;
      if (PcLoadEnable !== 1'b1 || PcLoadValue !== 16'h0100 || MemReadEnable !== 1'b0) begin
         n_errors++;
         $display("FAIL flush_cycle: got ple=%b plv=%h mre=%b, required 1/0100/0",
                  PcLoadEnable, PcLoadValue, MemReadEnable);
      end
      @(posedge Clock); #1;
      Flush = 1'b0; InstrReady = 1'b1;
      push_expected(16'h0100, 4);
      @(negedge Clock);
      n_checks++;
      if (InstrValid !== 1'b0 || MemReadEnable !== 1'b1 || MemAddress !== 16'h0100) begin
         n_errors++;
         $display("FAIL flush_next: got iv=%b mre=%b ma=%h, required 0/1/0100",
                  InstrValid, MemReadEnable, MemAddress);
      end
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
         @(posedge Clock); #1;
         @(negedge Clock);
         if (InstrValid && InstrReady) begin
            n_checks++;
            e = exp_q.pop_front();
            if (InstrAddress !== e.addr || Instruction !== e.data) begin
               n_errors++;
               $display("FAIL flush_word: got addr=%h data=%h, required addr=%h data=%h",
                        InstrAddress, Instruction, e.addr, e.data);
            end else $display("[flush] addr=%h data=%h", InstrAddress, Instruction);
         end
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL flush_timeout: %0d words undelivered, required 0", exp_q.size());
      end
   endtask

   task automatic test_flush_pop();
      exp_t e;
      do_reset(1'b0);
      repeat (6) @(posedge Clock);
      #1;
      InstrReady = 1'b1; Flush = 1'b1; FlushAddress = 16'h0200;
      @(negedge Clock);
      n_checks++;
      if (PcLoadEnable !== 1'b1 || PcLoadValue !== 16'h0200 || MemReadEnable !== 1'b0) begin
         n_errors++;
         $display("FAIL flushpop_cycle: got ple=%b plv=%h mre=%b, required 1/0200/0",
                  PcLoadEnable, PcLoadValue, MemReadEnable);
      end
      @(posedge Clock); #1;
      Flush = 1'b0; InstrReady = 1'b0;
      @(negedge Clock);
      n_checks++;
      if (InstrValid !== 1'b0) begin
         n_errors++;
         $display("FAIL flushpop_empty: InstrValid=%b, required 0", InstrValid);
      end
      @(posedge Clock); #1;
      InstrReady = 1'b1;
      push_expected(16'h0200, 4);
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
         @(negedge Clock);
         if (InstrValid && InstrReady) begin
            n_checks++;
            e = exp_q.pop_front();
            if (InstrAddress !== e.addr || Instruction !== e.data) begin
               n_errors++;
               $display("FAIL flushpop_word: got addr=%h data=%h, required addr=%h data=%h",
                        InstrAddress, Instruction, e.addr, e.data);
            end else $display("[flush_pop] addr=%h data=%h", InstrAddress, Instruction);
         end
         @(posedge Clock); #1;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL flushpop_timeout: %0d words undelivered, required 0", exp_q.size());
      end
   endtask

   task automatic test_wrap();
      exp_t e;
      do_reset(1'b1);
      @(posedge Clock); #1;
      Flush = 1'b1; FlushAddress = 16'hFFFE;
      @(posedge Clock); #1;
      Flush = 1'b0;
      push_expected(16'hFFFE, 4);
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
         @(negedge Clock);
         if (InstrValid && InstrReady) begin
            n_checks++;
            e = exp_q.pop_front();
            if (InstrAddress !== e.addr || Instruction !== e.data) begin
               n_errors++;
               $display("FAIL wrap_word: got addr=%h data=%h, required addr=%h data=%h",
                        InstrAddress, Instruction, e.addr, e.data);
            end else $display("[wrap] addr=%h data=%h", InstrAddress, Instruction);
         end
         @(posedge Clock); #1;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL wrap_timeout: %0d words undelivered, required 0", exp_q.size());
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      logic        prev_hold = 1'b0;
      logic [15:0] prev_ins  = 16'h0;
      logic [15:0] prev_addr = 16'h0;
      do_reset(1'b0);
      push_expected(16'h0000, 40);
      for (int c = 0; c < 400 && exp_q.size() != 0; c++) begin
         InstrReady = 1'($urandom_range(0, 1));
         @(negedge Clock);
         if (prev_hold) begin
            n_checks++;
            if (InstrValid !== 1'b1 || Instruction !== prev_ins || InstrAddress !== prev_addr) begin
               n_errors++;
               $display("FAIL hold_stable: got iv=%b ins=%h ia=%h, required 1/%h/%h",
                        InstrValid, Instruction, InstrAddress, prev_ins, prev_addr);
            end
         end
         if (InstrValid && InstrReady) begin
            n_checks++;
            e = exp_q.pop_front();
            if (InstrAddress !== e.addr || Instruction !== e.data) begin
               n_errors++;
               $display("FAIL b2b_word: got addr=%h data=%h, required addr=%h data=%h",
                        InstrAddress, Instruction, e.addr, e.data);
            end else $display("[back_to_back] addr=%h data=%h", InstrAddress, Instruction);
         end
         prev_hold = InstrValid & ~InstrReady;
         prev_ins  = Instruction;
         prev_addr = InstrAddress;
         @(posedge Clock); #1;
      end
      InstrReady = 1'b0;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL b2b_timeout: %0d words undelivered, required 0", exp_q.size());
      end
   endtask

   task automatic test_reset_midstream();
      exp_t e;
      int first_valid = -1;
      do_reset(1'b1);
      push_expected(16'h0000, 4);
      for (int c = 0; c < 6; c++) begin
         @(negedge Clock);
         if (InstrValid && InstrReady && exp_q.size() != 0) begin
            n_checks++;
            e = exp_q.pop_front();
            if (InstrAddress !== e.addr || Instruction !== e.data) begin
               n_errors++;
               $display("FAIL midrst_pre_word: got addr=%h data=%h, required addr=%h data=%h",
                        InstrAddress, Instruction, e.addr, e.data);
            end else $display("[midstream] addr=%h data=%h", InstrAddress, Instruction);
         end
         @(posedge Clock); #1;
      end
      Reset = 1'b0;
      @(negedge Clock);
      n_checks++;
      if ({MemReadEnable, PcLoadEnable, InstrValid} !== 3'b000 || PcLoadValue !== 16'h0 ||
          MemAddress !== 16'h0 || Instruction !== 16'h0 || InstrAddress !== 16'h0) begin
         n_errors++;
         $display("FAIL midrst_outputs: got mre=%b ple=%b iv=%b plv=%h ma=%h ins=%h ia=%h, required all 0",
                  MemReadEnable, PcLoadEnable, InstrValid, PcLoadValue, MemAddress, Instruction, InstrAddress);
      end
      @(posedge Clock); #1;
      Reset = 1'b1;
      exp_q.delete();
      push_expected(16'h0000, 4);
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
         @(negedge Clock);
         if (first_valid < 0 && InstrValid === 1'b1) first_valid = c;
         if (InstrValid && InstrReady) begin
            n_checks++;
            e = exp_q.pop_front();
            if (InstrAddress !== e.addr || Instruction !== e.data) begin
               n_errors++;
               $display("FAIL midrst_word: got addr=%h data=%h, required addr=%h data=%h",
                        InstrAddress, Instruction, e.addr, e.data);
            end else $display("[midstream] addr=%h data=%h", InstrAddress, Instruction);
         end
         @(posedge Clock); #1;
      end
      n_checks++;
      if (first_valid != 2 || exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL midrst_restart: first valid cycle %0d with %0d undelivered, required 2 and 0",
                  first_valid, exp_q.size());
      end
   endtask

`ifdef IFETCH_STALL_COUNT_EN
   task automatic test_stall_count();
      do_reset(1'b0);
      repeat (20) @(posedge Clock);
      @(negedge Clock);
      n_checks++;
      if (StallCount !== 16'd16) begin
         n_errors++;
         $display("FAIL stall_count: got %0d, required 16", StallCount);
      end
      @(posedge Clock); #1;
      Flush = 1'b1; FlushAddress = 16'h0040;
      @(posedge Clock); #1;
      Flush = 1'b0;
      @(negedge Clock);
      n_checks++;
      if (StallCount !== 16'd0) begin
         n_errors++;
         $display("FAIL stall_count_clear: got %0d, required 0", StallCount);
      end
      $display("[stall_count] counted and cleared");
   endtask
`endif

   initial begin
      Reset = 1'b0; Flush = 1'b0; FlushAddress = 16'h0000; InstrReady = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_flush_pop();
      test_wrap();
      test_back_to_back();
      test_reset_midstream();
`ifdef IFETCH_STALL_COUNT_EN
      test_stall_count();
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
